de_stage_reg: RTL and testbench
===============================

# de_stage_reg

Parametrised decode-to-execute pipeline register for the pipelined MIPS core, sitting between the D-stage register-file/forwarding mux and the E-stage ALU/MDU. It latches the decoded instruction, N register operands, PC and exception metadata, and precomputes the immediate variants. It distinguishes three control actions:
- **Bubble insertion** on a D-stage stall.
- **Freeze** while the E stage is busy, with late operand refresh.
- **Flush** on branch/exception.

It carries a valid bit so bubbles are explicit.

## Interface
Parameters:
- DATA_W, 32, width of each register operand channel
- NUM_OPND, 2, number of operand channels (rs, rt, ...)
- PERF_W, 16, width of performance counters (used only with DE_PERF_CNT_EN)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard E-stage content (branch-likely/exception)
- hold_e  in  1  E stage busy (MDU); freeze all E registers
- stall_d  in  1  D-stage hazard stall; insert bubble into E
- d_valid  in  1  D stage holds a real instruction
- d_instr  in  32  decoded instruction word
- d_opnd  in  NUM_OPND*DATA_W  forwarded operands, channel i at [i*DATA_W +: DATA_W]
- d_pc  in  32  PC of D instruction
- d_bd  in  1  D instruction is in a branch delay slot
- d_exc  in  5  exception code raised in F/D (0 = none)
- upd_en  in  NUM_OPND  per-channel late-forward strobe during hold
- upd_data  in  NUM_OPND*DATA_W  late-forward values
- e_valid  out  1  E holds a real instruction
- e_instr  out  32  latched instruction (0 = nop)
- e_opnd  out  NUM_OPND*DATA_W  latched operands
- e_pc, e_pc8  out  32  latched PC and PC+8
- e_imm_zext, e_imm_sext, e_imm_lui, e_shamt  out  32  immediate variants
- e_bd  out  1, e_exc  out  5  exception metadata
- perf_bubble_cnt, perf_hold_cnt  out  PERF_W  (only with DE_PERF_CNT_EN)

## Operation
Per-edge priority, highest first:
1. **reset:** every output register is 0, including e_pc and e_pc8. e_valid=0. Counters are 0.
2. **flush:** identical to reset for the data registers; counters are unchanged. flush wins over hold_e.
3. **hold_e:** all registers keep their value, except operand channel i, which loads upd_data[i] when upd_en[i]=1. upd_en is ignored in every other case.
4. **stall_d (bubble):**
   - e_valid=0, e_instr=0, operands=0, immediates=0, e_exc=0.
   - e_pc=d_pc, e_pc8=d_pc+8 and e_bd=d_bd are preserved, so the EPC of a bubble still points at the stalled instruction.
5. **load:**
   - e_valid=d_valid; instr, operands, pc, bd and exc are copied.
   - e_pc8 = d_pc+8, modulo 2^32 (wraps: 0xFFFFFFFC -> 0x00000004).
   - e_imm_zext = {16'b0, instr[15:0]}.
   - e_imm_sext = sign-extended instr[15:0].
   - e_imm_lui = {instr[15:0], 16'b0}.
   - e_shamt = {27'b0, instr[10:6]}.
   - If d_valid=0, the data is still captured but e_valid=0.

Further rules:
- Simultaneous stall_d and hold_e: hold_e wins. The D stall is absorbed because D is also frozen by the hazard unit.
- The block contains no combinational path from any input to any output.

## Timing
- Latency is 1 cycle: inputs sampled at edge n are visible after edge n.
- hold_e may stay asserted for any number of cycles. Content is stable for the whole hold, except for upd_en writes, which appear 1 cycle after the strobe.
- Deasserting reset mid-hold: outputs stay 0 until the first load.
- Flush during a hold clears immediately; e_valid is 0 the next cycle.

## Configuration
- DE_PERF_CNT_EN defined:
  - perf_bubble_cnt increments on every edge that takes the stall_d branch.
  - perf_hold_cnt increments on every edge that takes the hold_e branch.
  - Both saturate at 2^PERF_W-1 and clear only on reset.
- DE_PERF_CNT_EN undefined: counters and their ports are removed; all other behaviour is identical.

## Test plan
- **Load:** d_instr=0x2408FFFF (addiu), d_pc=0x00003000, d_valid=1 -> next cycle:
  - e_valid=1
  - e_imm_sext=0xFFFFFFFF, e_imm_zext=0x0000FFFF, e_imm_lui=0xFFFF0000
  - e_pc8=0x00003008
- **Bubble:** stall_d=1 with d_pc=0x3010, d_bd=1 -> e_valid=0, e_instr=0, e_opnd=0, e_pc=0x3010, e_bd=1. With DE_PERF_CNT_EN, perf_bubble_cnt +1.
- **Hold with refresh:** hold_e=1 for 3 cycles, upd_en=2'b10 with upd_data channel 1 = 0x12345678 in cycle 2 -> channel 1 becomes 0x12345678; channel 0 and all other fields are unchanged; perf_hold_cnt +3.
- **Priority:** flush=1 with hold_e=1 and stall_d=1 -> all zero, e_valid=0. Next: hold_e=1 and stall_d=1 -> contents held.
- **Wrap/reset:** d_pc=0xFFFFFFFC -> e_pc8=0x00000004. reset asserted mid-hold -> all outputs and counters 0 the next cycle.

Source files
------------

// File: rtl/de_stage_reg.sv
// de_stage_reg -- decode-to-execute pipeline register for the pipelined MIPS core.
//
// Latches the decoded instruction, NUM_OPND register operands, PC and
// exception metadata from D into E. It also precomputes the immediate
// variants so the E stage does not have to.
//
// Per-edge priority, highest first:
//   reset  : everything to zero, including the counters
//   flush  : data registers to zero; the counters keep their value
//   hold_e : everything keeps its value; operand channels may be
//            refreshed through upd_en/upd_data
//   stall_d: a bubble is inserted. The PC, PC+8 and delay-slot bit are
//            still captured so the EPC of the bubble names the stalled
//            instruction.
//   load   : normal capture of the D-stage instruction
//
// Ports:
//   clk, reset (sync, active-high), flush, hold_e, stall_d
//   d_valid, d_instr, d_opnd, d_pc, d_bd, d_exc   D-stage inputs
//   upd_en, upd_data                              late-forward refresh used only during hold_e
//   e_valid, e_instr, e_opnd, e_pc, e_pc8         E-stage outputs
//   e_imm_zext, e_imm_sext, e_imm_lui, e_shamt    precomputed immediates
//   e_bd, e_exc                                   exception metadata
//   perf_bubble_cnt, perf_hold_cnt                saturating counters
//
// Optional feature: define DE_PERF_CNT_EN to build the two performance
// counters and their ports. When it is undefined they are removed.
//
// Every output comes straight from a register, so there is no
// combinational path from any input to any output.

module de_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int NUM_OPND = 2,
  parameter int PERF_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       hold_e,
  input  logic                       stall_d,
  input  logic                       d_valid,
  input  logic [31:0]                d_instr,
  input  logic [NUM_OPND*DATA_W-1:0] d_opnd,
  input  logic [31:0]                d_pc,
  input  logic                       d_bd,
  input  logic [4:0]                 d_exc,
  input  logic [NUM_OPND-1:0]        upd_en,
  input  logic [NUM_OPND*DATA_W-1:0] upd_data,
  output logic                       e_valid,
  output logic [31:0]                e_instr,
  output logic [NUM_OPND*DATA_W-1:0] e_opnd,
  output logic [31:0]                e_pc,
  output logic [31:0]                e_pc8,
  output logic [31:0]                e_imm_zext,
  output logic [31:0]                e_imm_sext,
  output logic [31:0]                e_imm_lui,
  output logic [31:0]                e_shamt,
  output logic                       e_bd,
  output logic [4:0]                 e_exc
`ifdef DE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]          perf_bubble_cnt,
  output logic [PERF_W-1:0]          perf_hold_cnt
`endif
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc8_q, pc8_d;
  logic [31:0] zext_q, zext_d;
  logic [31:0] sext_q, sext_d;
  logic [31:0] lui_q, lui_d;
  logic [31:0] shamt_q, shamt_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_q, exc_d;

  // Next state for the non-operand fields.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pc8_d   = pc8_q;
    zext_d  = zext_q;
    sext_d  = sext_q;
    lui_d   = lui_q;
    shamt_d = shamt_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    if (reset || flush) begin
      valid_d = 1'b0;
      instr_d = '0;
      pc_d    = '0;
      pc8_d   = '0;
      zext_d  = '0;
      sext_d  = '0;
      lui_d   = '0;
      shamt_d = '0;
      bd_d    = 1'b0;
      exc_d   = '0;
    end else if (hold_e) begin
      // The defaults above already hold every field.
    end else if (stall_d) begin
      // In a bubble the PC and bd still follow D, so the EPC stays correct.
      valid_d = 1'b0;
      instr_d = '0;
      pc_d    = d_pc;
      pc8_d   = d_pc + 32'd8;
      zext_d  = '0;
      sext_d  = '0;
      lui_d   = '0;
      shamt_d = '0;
      bd_d    = d_bd;
      exc_d   = '0;
    end else begin
      valid_d = d_valid;
      instr_d = d_instr;
      pc_d    = d_pc;
      pc8_d   = d_pc + 32'd8;
      zext_d  = {16'h0000, d_instr[15:0]};
      sext_d  = {{16{d_instr[15]}}, d_instr[15:0]};
      lui_d   = {d_instr[15:0], 16'h0000};
      shamt_d = {27'd0, d_instr[10:6]};
      bd_d    = d_bd;
      exc_d   = d_exc;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    instr_q <= instr_d;
    pc_q    <= pc_d;
    pc8_q   <= pc8_d;
    zext_q  <= zext_d;
    sext_q  <= sext_d;
    lui_q   <= lui_d;
    shamt_q <= shamt_d;
    bd_q    <= bd_d;
    exc_q   <= exc_d;
  end

  // Operand channels. Each channel is refreshed on its own during a hold,
  // so each one has its own register and next-state logic.
  generate
    for (genvar gi = 0; gi < NUM_OPND; gi++) begin : g_opnd
      logic [DATA_W-1:0] opnd_q, opnd_d;

      always_comb begin
        opnd_d = opnd_q;
        if (reset || flush) begin
          opnd_d = '0;
        end else if (hold_e) begin
          if (upd_en[gi]) opnd_d = upd_data[gi*DATA_W +: DATA_W];
        end else if (stall_d) begin
          opnd_d = '0;
        end else begin
          opnd_d = d_opnd[gi*DATA_W +: DATA_W];
        end
      end

      always_ff @(posedge clk) begin
        opnd_q <= opnd_d;
      end

      assign e_opnd[gi*DATA_W +: DATA_W] = opnd_q;
    end
  endgenerate

  assign e_valid    = valid_q;
  assign e_instr    = instr_q;
  assign e_pc       = pc_q;
  assign e_pc8      = pc8_q;
  assign e_imm_zext = zext_q;
  assign e_imm_sext = sext_q;
  assign e_imm_lui  = lui_q;
  assign e_shamt    = shamt_q;
  assign e_bd       = bd_q;
  assign e_exc      = exc_q;

`ifdef DE_PERF_CNT_EN
  logic [PERF_W-1:0] bub_cnt_q, bub_cnt_d;
  logic [PERF_W-1:0] hold_cnt_q, hold_cnt_d;

  // A counter only steps on the edges that actually take its branch. A
  // flush outranks both branches, so a flush edge counts nothing. Both
  // counters saturate at all ones.
  always_comb begin
    bub_cnt_d  = bub_cnt_q;
    hold_cnt_d = hold_cnt_q;
    if (reset) begin
      bub_cnt_d  = '0;
      hold_cnt_d = '0;
    end else if (!flush) begin
      if (hold_e) begin
        if (hold_cnt_q != {PERF_W{1'b1}}) hold_cnt_d = hold_cnt_q + 1'b1;
      end else if (stall_d) begin
        if (bub_cnt_q != {PERF_W{1'b1}}) bub_cnt_d = bub_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    bub_cnt_q  <= bub_cnt_d;
    hold_cnt_q <= hold_cnt_d;
  end

  assign perf_bubble_cnt = bub_cnt_q;
  assign perf_hold_cnt   = hold_cnt_q;
`else
  // PERF_W only sizes the counters. This empty block keeps the parameter
  // referenced when the counters are not built.
  if (PERF_W > 0) begin : g_no_perf
  end
`endif

endmodule

// File: tb/tb_de_stage_reg.sv
module tb_de_stage_reg;

  localparam int DATA_W   = 32;
  localparam int NUM_OPND = 2;
  localparam int PERF_W   = 16;

  logic        clk = 1'b0;
  logic        reset, flush, hold_e, stall_d, d_valid, d_bd;
  logic [31:0] d_instr, d_pc;
  logic [63:0] d_opnd, upd_data;
  logic [4:0]  d_exc;
  logic [1:0]  upd_en;
  logic        e_valid, e_bd;
  logic [31:0] e_instr, e_pc, e_pc8, e_imm_zext, e_imm_sext, e_imm_lui, e_shamt;
  logic [63:0] e_opnd;
  logic [4:0]  e_exc;
`ifdef DE_PERF_CNT_EN
  logic [PERF_W-1:0] perf_bubble_cnt, perf_hold_cnt;
`endif

  always #5 clk = ~clk;

  de_stage_reg #(.DATA_W(DATA_W), .NUM_OPND(NUM_OPND), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .hold_e(hold_e), .stall_d(stall_d),
    .d_valid(d_valid), .d_instr(d_instr), .d_opnd(d_opnd), .d_pc(d_pc),
    .d_bd(d_bd), .d_exc(d_exc), .upd_en(upd_en), .upd_data(upd_data),
    .e_valid(e_valid), .e_instr(e_instr), .e_opnd(e_opnd), .e_pc(e_pc),
    .e_pc8(e_pc8), .e_imm_zext(e_imm_zext), .e_imm_sext(e_imm_sext),
    .e_imm_lui(e_imm_lui), .e_shamt(e_shamt), .e_bd(e_bd), .e_exc(e_exc)
`ifdef DE_PERF_CNT_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_hold_cnt(perf_hold_cnt)
`endif
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [63:0] opnd;
    logic [31:0] pc, pc8, zext, sext, lui, shamt;
    logic        bd;
    logic [4:0]  exc;
    logic [15:0] bub, hold;
  } st_t;

  st_t model = '0;
  st_t exp_q[$];
  int  tests_run = 0;
  int  tests_failed = 0;
  int  cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behaviour of the register for one edge, using the inputs as they are driven now.
  function automatic st_t next_st(input st_t s);
    st_t n = s;
    if (reset) begin
      n = '0;
    end else if (flush) begin
      n = '0;
      n.bub  = s.bub;
      n.hold = s.hold;
    end else if (hold_e) begin
      if (upd_en[0]) n.opnd[31:0]  = upd_data[31:0];
      if (upd_en[1]) n.opnd[63:32] = upd_data[63:32];
      if (s.hold != 16'hFFFF) n.hold = s.hold + 16'd1;
    end else if (stall_d) begin
      n = '0;
      n.pc   = d_pc;
      n.pc8  = d_pc + 32'd8;
      n.bd   = d_bd;
      n.bub  = (s.bub != 16'hFFFF) ? s.bub + 16'd1 : s.bub;
      n.hold = s.hold;
    end else begin
      n.valid = d_valid;
      n.instr = d_instr;
      n.opnd  = d_opnd;
      n.pc    = d_pc;
      n.pc8   = d_pc + 32'd8;
      n.zext  = {16'h0000, d_instr[15:0]};
      n.sext  = d_instr[15] ? {16'hFFFF, d_instr[15:0]} : {16'h0000, d_instr[15:0]};
      n.lui   = {d_instr[15:0], 16'h0000};
      n.shamt = {27'd0, d_instr[10:6]};
      n.bd    = d_bd;
      n.exc   = d_exc;
    end
    return n;
  endfunction

  // One clock edge: push the expected state, wait for the edge, then pop the
  // expected state and compare it with the DUT.
  task automatic cycle();
    st_t ex;
    model = next_st(model);
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    cyc++;
    ex = exp_q.pop_front();
    $display("[TB] cyc %0d rst=%0b fl=%0b hold=%0b stall=%0b -> valid=%0b instr=%h pc=%h opnd=%h",
             cyc, reset, flush, hold_e, stall_d, e_valid, e_instr, e_pc, e_opnd);
    check_eq("valid", e_valid, ex.valid);
    check_eq("instr", e_instr, ex.instr);
    check_eq("opnd", e_opnd, ex.opnd);
    check_eq("pc", e_pc, ex.pc);
    check_eq("pc8", e_pc8, ex.pc8);
    check_eq("zext", e_imm_zext, ex.zext);
    check_eq("sext", e_imm_sext, ex.sext);
    check_eq("lui", e_imm_lui, ex.lui);
    check_eq("shamt", e_shamt, ex.shamt);
    check_eq("bd", e_bd, ex.bd);
    check_eq("exc", e_exc, ex.exc);
`ifdef DE_PERF_CNT_EN
    check_eq("bub_cnt", perf_bubble_cnt, ex.bub);
    check_eq("hold_cnt", perf_hold_cnt, ex.hold);
`endif
  endtask

  task automatic set_ctl(input logic r, input logic f, input logic h, input logic s);
    reset = r; flush = f; hold_e = h; stall_d = s;
  endtask

  initial begin
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    d_valid = 1'b1; d_instr = 32'hFFFFFFFF; d_opnd = 64'h1; d_pc = 32'h1234;
    d_bd = 1'b1; d_exc = 5'd3; upd_en = 2'b00; upd_data = '0;

    // Reset state: every output is 0.
    cycle();
    cycle();
    check_eq("rst_pc8", e_pc8, 32'h0);
    check_eq("rst_valid", e_valid, 1'b0);

    // Load of an addiu instruction.
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    d_valid = 1'b1; d_instr = 32'h2408FFFF; d_pc = 32'h00003000; d_bd = 1'b0;
    d_exc = 5'd0; d_opnd = {32'hBBBB0001, 32'hAAAA0000};
    cycle();
    check_eq("ld_valid", e_valid, 1'b1);
    check_eq("ld_sext", e_imm_sext, 32'hFFFFFFFF);
    check_eq("ld_zext", e_imm_zext, 32'h0000FFFF);
    check_eq("ld_lui", e_imm_lui, 32'hFFFF0000);
    check_eq("ld_pc8", e_pc8, 32'h00003008);

    // Bubble: upd_en must have no effect outside a hold.
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    d_pc = 32'h3010; d_bd = 1'b1; d_instr = 32'h01234567; upd_en = 2'b11;
    upd_data = {32'hCAFE0001, 32'hCAFE0000};
    cycle();
    check_eq("bub_valid", e_valid, 1'b0);
    check_eq("bub_instr", e_instr, 32'h0);
    check_eq("bub_opnd", e_opnd, 64'h0);
    check_eq("bub_pc", e_pc, 32'h3010);
    check_eq("bub_bd", e_bd, 1'b1);
    upd_en = 2'b00;

    // sll-type load with shamt 2 and exception code 4.
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    d_instr = 32'h00021880; d_pc = 32'h3014; d_bd = 1'b0; d_exc = 5'd4;
    d_opnd = {32'h11111111, 32'h22222222};
    cycle();
    check_eq("ld_shamt", e_shamt, 32'd2);
    check_eq("ld_exc", e_exc, 5'd4);

    // Hold for 3 cycles, with a refresh of channel 1 in the second cycle.
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    d_instr = 32'hFFFFFFFF; d_pc = 32'h5000; d_opnd = '1;
    cycle();
    upd_en = 2'b10; upd_data = {32'h12345678, 32'hDEADBEEF};
    cycle();
    upd_en = 2'b00;
    cycle();
    check_eq("hold_ch1", e_opnd[63:32], 32'h12345678);
    check_eq("hold_ch0", e_opnd[31:0], 32'h22222222);
    check_eq("hold_pc", e_pc, 32'h3014);

    // Priority: flush beats hold and stall, then hold beats stall.
    set_ctl(1'b0, 1'b1, 1'b1, 1'b1);
    cycle();
    check_eq("flush_valid", e_valid, 1'b0);
    check_eq("flush_pc", e_pc, 32'h0);
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
    cycle();

    // Load, then hold and stall together: the contents are held.
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    d_valid = 1'b1; d_instr = 32'h3C01ABCD; d_pc = 32'h4000; d_opnd = {32'h5, 32'h6};
    cycle();
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
    d_pc = 32'h4444;
    cycle();
    check_eq("hs_pc", e_pc, 32'h4000);
    check_eq("hs_valid", e_valid, 1'b1);

    // PC+8 wraps modulo 2^32.
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    d_pc = 32'hFFFFFFFC;
    cycle();
    check_eq("wrap_pc8", e_pc8, 32'h00000004);

    // With d_valid=0 the data is still captured but e_valid stays 0.
    d_valid = 1'b0; d_pc = 32'h6000;
    cycle();
    check_eq("inv_pc", e_pc, 32'h6000);
    check_eq("inv_valid", e_valid, 1'b0);

    // Reset in the middle of a hold; outputs stay 0 while the hold continues.
    d_valid = 1'b1;
    cycle();
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0);
    cycle();
    check_eq("rsth_pc", e_pc, 32'h0);
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    cycle();
    check_eq("rsth_instr", e_instr, 32'h0);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      reset   = ($urandom_range(63) == 0);
      flush   = ($urandom_range(15) == 0);
      hold_e  = ($urandom_range(3) == 0);
      stall_d = ($urandom_range(3) == 0);
      d_valid = 1'($urandom);
      d_instr = $urandom;
      d_opnd  = {$urandom, $urandom};
      d_pc    = $urandom;
      d_bd    = 1'($urandom);
      d_exc   = 5'($urandom);
      upd_en  = 2'($urandom);
      upd_data = {$urandom, $urandom};
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
